// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, animator state encoding and bounce step
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CW       = 11;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2,
    COMMIT = 2'd3
  } anim_state_t;

  typedef struct packed {
    coord_t pos;
    logic   neg;   // 1 = moving toward 0
  } axis_t;

  // One axis step; lands exactly on an edge and flips direction there.
  function automatic axis_t bounce_step(coord_t pos, logic neg, logic [2:0] step, coord_t max_pos);
    logic [CW:0] w_sum;
    logic [CW:0] w_step;
    axis_t       r_out;
    w_step    = {{(CW-2){1'b0}}, step};
    w_sum     = {1'b0, pos} + w_step;
    r_out.pos = pos;
    r_out.neg = neg;
    if (step != 3'd0) begin
      if (!neg) begin
        if (w_sum >= {1'b0, max_pos}) begin
          r_out.pos = max_pos;
          r_out.neg = 1'b1;
        end else begin
          r_out.pos = w_sum[CW-1:0];
        end
      end else begin
        if ({1'b0, pos} <= w_step) begin
          r_out.pos = '0;
          r_out.neg = 1'b0;
        end else begin
          r_out.pos = pos - coord_t'(step);
        end
      end
    end
    return r_out;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-flop synchroniser with a one-cycle rising-edge pulse
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1   // idle level of the input, avoids a false edge out of reset
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/box_animator.sv
// rtl/box_animator.sv - bounces a SIZE x SIZE square around the active area, one step per frame
module box_animator
  import vga_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int CW       = vga_pkg::CW
) (
  input  logic          CLOCK_50,
  input  logic          nReset,
  input  logic          VGA_VS,
  input  logic          pause,
  input  logic [2:0]    speed,
  input  logic          load_valid,
  input  logic [CW-1:0] load_x,
  input  logic [CW-1:0] load_y,
  output logic          load_ready,
  output logic [CW-1:0] x1,
  output logic [CW-1:0] x2,
  output logic [CW-1:0] y1,
  output logic [CW-1:0] y2,
  output logic [15:0]   frame_count
);

  localparam logic [CW-1:0] X_MAX  = CW'(H_ACTIVE - SIZE);
  localparam logic [CW-1:0] Y_MAX  = CW'(V_ACTIVE - SIZE);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  anim_state_t   r_state;
  anim_state_t   w_next_state;
  logic          w_tick;
  logic          w_accept;
  logic [2:0]    w_step;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_neg_x;
  logic          r_neg_y;
  logic [CW-1:0] w_load_x;
  logic [CW-1:0] w_load_y;
  axis_t         w_bx;
  axis_t         w_by;

  // Rising edge of VGA_VS marks the end of the sync pulse, still inside vertical blank.
  sync_edge_detect #(.RESET_VAL(1'b1)) u_vs_edge (
    .clk     (CLOCK_50),
    .rst_n   (nReset),
    .i_async (VGA_VS),
    .o_rise  (w_tick)
  );

  assign load_ready = (r_state == IDLE);
  assign w_accept   = load_valid && load_ready;
  assign w_step     = pause ? 3'd0 : speed;
  assign w_load_x   = (load_x > X_MAX) ? X_MAX : load_x;
  assign w_load_y   = (load_y > Y_MAX) ? Y_MAX : load_y;
  assign w_bx       = bounce_step(r_x, r_neg_x, w_step, X_MAX);
  assign w_by       = bounce_step(r_y, r_neg_y, w_step, Y_MAX);

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)    w_next_state = COMMIT;
        else if (w_tick) w_next_state = MOVE_X;
      end
      MOVE_X:  w_next_state = MOVE_Y;
      MOVE_Y:  w_next_state = COMMIT;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_neg_x     <= 1'b0;
      r_neg_y     <= 1'b0;
      x1          <= '0;
      x2          <= SIZE_C;
      y1          <= '0;
      y2          <= SIZE_C;
      frame_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick) frame_count <= frame_count + 16'd1;
          if (w_accept) begin
            r_x <= w_load_x;
            r_y <= w_load_y;
          end
        end
        MOVE_X: begin
          r_x     <= w_bx.pos;
          r_neg_x <= w_bx.neg;
        end
        MOVE_Y: begin
          r_y     <= w_by.pos;
          r_neg_y <= w_by.neg;
        end
        COMMIT: begin
          x1 <= r_x;
          x2 <= r_x + SIZE_C;
          y1 <= r_y;
          y2 <= r_y + SIZE_C;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_box_animator.sv
// tb/tb_box_animator.sv - directed self-checking bench for box_animator
module tb_box_animator;

  logic        CLOCK_50 = 1'b0;
  logic        nReset   = 1'b0;
  logic        VGA_VS   = 1'b1;
  logic        pause    = 1'b0;
  logic [2:0]  speed    = 3'd4;
  logic        load_valid = 1'b0;
  logic [10:0] load_x   = '0;
  logic [10:0] load_y   = '0;
  logic        load_ready;
  logic [10:0] x1, x2, y1, y2;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  box_animator dut (
    .CLOCK_50    (CLOCK_50),
    .nReset      (nReset),
    .VGA_VS      (VGA_VS),
    .pause       (pause),
    .speed       (speed),
    .load_valid  (load_valid),
    .load_x      (load_x),
    .load_y      (load_y),
    .load_ready  (load_ready),
    .x1          (x1),
    .x2          (x2),
    .y1          (y1),
    .y2          (y2),
    .frame_count (frame_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_box(input string tag, input int ex, input int ey);
    check({tag, ".x1"}, 32'(x1), 32'(ex));
    check({tag, ".x2"}, 32'(x2), 32'(ex + 32));
    check({tag, ".y1"}, 32'(y1), 32'(ey));
    check({tag, ".y2"}, 32'(y2), 32'(ey + 32));
  endtask

  // Low sync pulse then return high; leaves time for the full move sequence.
  task automatic frame();
    @(negedge CLOCK_50) VGA_VS = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_load(input int lx, input int ly);
    @(negedge CLOCK_50);
    load_valid = 1'b1;
    load_x     = 11'(lx);
    load_y     = 11'(ly);
    @(posedge CLOCK_50);
    #1 load_valid = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_box("reset", 0, 0);
    check("reset.load_ready", 32'(load_ready), 32'd1);
    nReset = 1'b1;
    repeat (20) @(posedge CLOCK_50);
    #1;
    check_box("idle", 0, 0);
    check("idle.load_ready", 32'(load_ready), 32'd1);
    check("idle.fc", 32'(frame_count), 32'd0);

    // Latency: sampled high at E0, outputs update at E5.
    @(negedge CLOCK_50) VGA_VS = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    @(posedge CLOCK_50);
    repeat (4) @(posedge CLOCK_50);
    #1 check("lat.e4.x1", 32'(x1), 32'd0);
    @(posedge CLOCK_50);
    #1 check_box("lat.e5", 4, 4);
    check("lat.fc", 32'(frame_count), 32'd1);
    repeat (10000) @(posedge CLOCK_50);
    #1 check_box("hold", 4, 4);
    check("hold.fc", 32'(frame_count), 32'd1);

    do_load(600, 440);
    check_box("load", 600, 440);
    frame(); check_box("f1", 604, 444);
    frame(); check_box("f2", 608, 448);
    frame(); check_box("f3", 604, 444);
    check("f3.fc", 32'(frame_count), 32'd4);

    do_load(2000, 1000);
    check_box("clamp", 608, 448);

    pause = 1'b1;
    frame(); frame(); frame();
    check_box("pause", 608, 448);
    check("pause.fc", 32'(frame_count), 32'd7);
    pause = 1'b0;
    speed = 3'd0;
    frame();
    check_box("speed0", 608, 448);
    check("speed0.fc", 32'(frame_count), 32'd8);
    speed = 3'd4;

    // Load presented in the cycle the tick is seen.
    @(negedge CLOCK_50) VGA_VS = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    load_valid = 1'b1;
    load_x     = 11'd100;
    load_y     = 11'd50;
    @(posedge CLOCK_50);
    #1 load_valid = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    #1 check_box("ldtick", 100, 50);
    check("ldtick.fc", 32'(frame_count), 32'd9);

    // Reset asserted while in MOVE_Y.
    @(negedge CLOCK_50) VGA_VS = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    @(posedge CLOCK_50);
    repeat (3) @(posedge CLOCK_50);
    #1 check("movey.load_ready", 32'(load_ready), 32'd0);
    nReset = 1'b0;
    #1;
    check_box("rstmid", 0, 0);
    check("rstmid.fc", 32'(frame_count), 32'd0);
    check("rstmid.load_ready", 32'(load_ready), 32'd1);
    repeat (2) @(posedge CLOCK_50);
    #1 nReset = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1 check_box("postrst", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
